// File: rtl/store_drain_if.sv
// Handshake bundle between the store drain, the store queue head and the
// data-memory write port. The master side is the drain itself.
interface store_drain_if #(
  parameter int ROB_IDX_WIDTH = 6,
  parameter int ADDR_WIDTH    = 32,
  parameter int DATA_WIDTH    = 32
);
  logic                     sq_head_valid;
  logic [ROB_IDX_WIDTH-1:0] sq_head_rob_tag;
  logic [ADDR_WIDTH-1:0]    sq_head_addr;
  logic [DATA_WIDTH-1:0]    sq_head_data;
  logic [DATA_WIDTH/8-1:0]  sq_head_be;
  logic                     sq_pop_valid;
  logic                     sq_pop_ready;

  logic                     mem_req_valid;
  logic                     mem_req_ready;
  logic [ADDR_WIDTH-1:0]    mem_req_addr;
  logic [DATA_WIDTH-1:0]    mem_req_data;
  logic [DATA_WIDTH/8-1:0]  mem_req_be;
  logic [ROB_IDX_WIDTH-1:0] mem_req_rob_tag;
  logic                     mem_ack;

  modport master (
    input  sq_head_valid, sq_head_rob_tag, sq_head_addr, sq_head_data, sq_head_be,
    input  sq_pop_ready, mem_req_ready, mem_ack,
    output sq_pop_valid,
    output mem_req_valid, mem_req_addr, mem_req_data, mem_req_be, mem_req_rob_tag
  );

  modport slave (
    output sq_head_valid, sq_head_rob_tag, sq_head_addr, sq_head_data, sq_head_be,
    output sq_pop_ready, mem_req_ready, mem_ack,
    input  sq_pop_valid,
    input  mem_req_valid, mem_req_addr, mem_req_data, mem_req_be, mem_req_rob_tag
  );
endinterface

// File: rtl/store_drain.sv
// Drains ROB-committed stores from the SQ head to the data-memory write port,
// one request in flight at a time, in program order.
module store_drain #(
  parameter int SQ_DEPTH      = 16,
  parameter int COMMIT_WIDTH  = 2,
  parameter int ROB_IDX_WIDTH = 6,
  parameter int ADDR_WIDTH    = 32,
  parameter int DATA_WIDTH    = 32,
  localparam int CW   = $clog2(COMMIT_WIDTH + 1),
  localparam int CNTW = $clog2(SQ_DEPTH + 1),
  localparam int CNTX = CNTW + 1,
  localparam int BEW  = DATA_WIDTH / 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [CW-1:0]     commit_store_cnt_i,
  store_drain_if.master     bus,
  output logic [CNTW-1:0]   committed_cnt_o,
  output logic              drained_o
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    WAIT_ACK = 2'd2
  } state_e;

  state_e                   state_q, state_d;
  logic [CNTW-1:0]          cnt_q, cnt_d;
  logic [ROB_IDX_WIDTH-1:0] tag_q, tag_d;
  logic [ADDR_WIDTH-1:0]    addr_q, addr_d;
  logic [DATA_WIDTH-1:0]    data_q, data_d;
  logic [BEW-1:0]           be_q, be_d;

  logic            popValid;
  logic            reqValid;
  logic            ackDec;
  logic [CNTX-1:0] cntSum;

  always_comb begin
    state_d  = state_q;
    tag_d    = tag_q;
    addr_d   = addr_q;
    data_d   = data_q;
    be_d     = be_q;
    popValid = 1'b0;
    reqValid = 1'b0;
    ackDec   = 1'b0;

    case (state_q)
      IDLE: begin
        if (cnt_q != '0 && bus.sq_head_valid) begin
          popValid = 1'b1;
          if (bus.sq_pop_ready) begin
            tag_d   = bus.sq_head_rob_tag;
            addr_d  = bus.sq_head_addr;
            data_d  = bus.sq_head_data;
            be_d    = bus.sq_head_be;
            state_d = REQ;
          end
        end
      end
      REQ: begin
        reqValid = 1'b1;
        if (bus.mem_req_ready) begin
          state_d = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (bus.mem_ack) begin
          ackDec  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Commit and acknowledge can land together; both take effect.
    cntSum = {1'b0, cnt_q} + CNTX'(commit_store_cnt_i) - CNTX'(ackDec);
    cnt_d  = cntSum[CNTW-1:0];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      tag_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      be_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tag_q   <= tag_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      be_q    <= be_d;
    end
  end

  assign bus.sq_pop_valid    = popValid;
  assign bus.mem_req_valid   = reqValid;
  assign bus.mem_req_addr    = addr_q;
  assign bus.mem_req_data    = data_q;
  assign bus.mem_req_be      = be_q;
  assign bus.mem_req_rob_tag = tag_q;
  assign committed_cnt_o     = cnt_q;
  assign drained_o           = (cnt_q == '0) && (state_q == IDLE);

`ifndef SYNTHESIS
  // Remembers a request the memory accepted but has not acknowledged, even
  // across a reset, so the ack of an abandoned request is tolerated.
  logic ackOwed;
  always_ff @(posedge clk_i) begin
    if (state_q == REQ && bus.mem_req_ready) begin
      ackOwed <= 1'b1;
    end else if (bus.mem_ack) begin
      ackOwed <= 1'b0;
    end
  end

  a_commit_width: assert property (@(posedge clk_i) disable iff (rst_i)
    commit_store_cnt_i <= CW'(COMMIT_WIDTH));
  a_cnt_range: assert property (@(posedge clk_i) disable iff (rst_i)
    cntSum <= CNTX'(SQ_DEPTH));
  a_head_valid: assert property (@(posedge clk_i) disable iff (rst_i)
    (state_q == IDLE && cnt_q != '0) |-> bus.sq_head_valid);
  a_ack_state: assert property (@(posedge clk_i) disable iff (rst_i)
    bus.mem_ack |-> (state_q == WAIT_ACK || ackOwed));
`endif

endmodule
